// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//
// Word-addressed memory target for the multi-cycle CPU's load/store and
// instruction-fetch requests. It handles one transaction at a time, inserts
// WAIT_CYCLES wait states between accept and access commit, and flags
// addresses beyond the implemented RAM instead of aliasing them.
//
// Parameters:
//   ADDR_WIDTH   implemented word-address bits; RAM depth is 2**ADDR_WIDTH
//   WAIT_CYCLES  wait states between accept and commit (0..15)
//
// Ports:
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   req_valid   in   request present
//   req_ready   out  responder can accept a request (registered)
//   req_we      in   1 = write, 0 = read
//   req_addr    in   32-bit word address
//   req_wdata   in   32-bit write data
//   resp_valid  out  response present (registered)
//   resp_ready  in   requester takes the response
//   resp_rdata  out  read data; 0 for writes and errors (registered)
//   resp_err    out  address out of range, no access performed (registered)
// -----------------------------------------------------------------------------
module mem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    // The counter counts down to zero, so it is loaded with one less than the
    // number of wait states. Clamped so a zero-wait build elaborates cleanly.
    localparam int          WAIT_M1   = (WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0;
    localparam logic [3:0]  WAIT_INIT = WAIT_M1[3:0];
    localparam logic        ZERO_WAIT = (WAIT_CYCLES == 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;

    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;

    logic [31:0] mem [0:DEPTH-1];

    logic                  accept;
    logic                  commit;
    logic                  c_we;
    logic [31:0]           c_addr;
    logic [31:0]           c_wdata;
    logic                  c_in_range;
    logic [ADDR_WIDTH-1:0] c_idx;
    logic                  mem_wr;

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

    // Handshake and commit-operand selection. In a zero-wait build the access
    // commits on the accept edge itself, so it must use the live request
    // inputs rather than the (not yet loaded) latched copy.
    always_comb begin
        accept  = (state_q == S_IDLE) && req_valid && req_ready_q;
        commit  = 1'b0;
        c_we    = we_q;
        c_addr  = addr_q;
        c_wdata = wdata_q;
        if (accept && ZERO_WAIT) begin
            commit  = 1'b1;
            c_we    = req_we;
            c_addr  = req_addr;
            c_wdata = req_wdata;
        end else if ((state_q == S_WAIT) && (cnt_q == 4'd0)) begin
            commit = 1'b1;
        end
    end

    always_comb begin
        c_in_range = ((c_addr >> ADDR_WIDTH) == 32'd0);
        c_idx      = c_addr[ADDR_WIDTH-1:0];
        // The RAM has no reset; gating with rst_n keeps a request presented
        // during reset from slipping a write into memory.
        mem_wr     = rst_n && commit && c_we && c_in_range;
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = ZERO_WAIT ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs. Decoded from the next state and registered, so the
    // handshake outputs change on the same edge as the state.
    always_comb begin
        req_ready_d  = (state_d == S_IDLE);
        resp_valid_d = (state_d == S_RESP);
    end

    // Request latches, wait counter and response data.
    always_comb begin
        cnt_d        = cnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;

        if (accept) begin
            we_d    = req_we;
            addr_d  = req_addr;
            wdata_d = req_wdata;
            cnt_d   = WAIT_INIT;
        end else if ((state_q == S_WAIT) && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end

        // Response fields are loaded only at commit and then hold through RESP.
        if (commit) begin
            resp_err_d   = !c_in_range;
            resp_rdata_d = (c_in_range && !c_we) ? mem[c_idx] : 32'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= 4'd0;
            we_q         <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Backing RAM, not reset.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem[c_idx] <= c_wdata;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
//
// Self-checking bench for mem_responder. Two instances share clock and reset:
// index 0 is the default build (ADDR_WIDTH=10, WAIT_CYCLES=2), index 1 is a
// zero-wait build. A table of directed transactions is applied to both, then
// hand-written sequences cover back-to-back zero-wait accepts, response
// backpressure and reset asserted during the wait window.
// -----------------------------------------------------------------------------
module tb_mem_responder;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_we;
    logic [1:0][31:0] req_addr;
    logic [1:0][31:0] req_wdata;
    logic [1:0]  resp_valid;
    logic [1:0]  resp_ready;
    logic [1:0][31:0] resp_rdata;
    logic [1:0]  resp_err;

    int n_vec = 0;
    int n_err = 0;

    mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) dut_w2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid[0]),
        .req_ready  (req_ready[0]),
        .req_we     (req_we[0]),
        .req_addr   (req_addr[0]),
        .req_wdata  (req_wdata[0]),
        .resp_valid (resp_valid[0]),
        .resp_ready (resp_ready[0]),
        .resp_rdata (resp_rdata[0]),
        .resp_err   (resp_err[0])
    );

    mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut_w0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid[1]),
        .req_ready  (req_ready[1]),
        .req_we     (req_we[1]),
        .req_addr   (req_addr[1]),
        .req_wdata  (req_wdata[1]),
        .resp_valid (resp_valid[1]),
        .resp_ready (resp_ready[1]),
        .resp_rdata (resp_rdata[1]),
        .resp_err   (resp_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t tbl [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Starts just after a rising edge. Presents one request, scrambles the
    // request inputs right after the accept edge, measures edges from accept
    // to resp_valid, checks the response, then completes the handshake.
    task automatic do_txn(input int d, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata,
                          input logic exp_err, input string tag);
        int lat;
        int exp_lat;
        exp_lat = (d == 0) ? 2 : 0;
        check({tag, " ready_before"}, {31'd0, req_ready[d]}, 32'd1);
        req_valid[d]  = 1'b1;
        req_we[d]     = we;
        req_addr[d]   = addr;
        req_wdata[d]  = wdata;
        resp_ready[d] = 1'b0;
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
        req_we[d]    = ~we;
        req_addr[d]  = addr ^ 32'h1;
        req_wdata[d] = ~wdata;
        lat = 0;
        while (!resp_valid[d] && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " rdata"}, resp_rdata[d], exp_rdata);
        check({tag, " err"}, {31'd0, resp_err[d]}, {31'd0, exp_err});
        resp_ready[d] = 1'b1;
        @(posedge clk); #1;
        resp_ready[d] = 1'b0;
        check({tag, " valid_after"}, {31'd0, resp_valid[d]}, 32'd0);
        check({tag, " ready_after"}, {31'd0, req_ready[d]}, 32'd1);
    endtask

    initial begin
        tbl[0]  = '{0, 1'b1, 32'h0000_0005, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
        tbl[1]  = '{0, 1'b0, 32'h0000_0005, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
        tbl[2]  = '{0, 1'b1, 32'h0000_0000, 32'h0000_1111, 32'h0000_0000, 1'b0};
        tbl[3]  = '{0, 1'b0, 32'h0000_0400, 32'h0000_0000, 32'h0000_0000, 1'b1};
        tbl[4]  = '{0, 1'b1, 32'h0000_0400, 32'h0000_0BAD, 32'h0000_0000, 1'b1};
        tbl[5]  = '{0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_1111, 1'b0};
        tbl[6]  = '{0, 1'b1, 32'hFFFF_FFFF, 32'h0000_5A5A, 32'h0000_0000, 1'b1};
        tbl[7]  = '{0, 1'b1, 32'h0000_03FF, 32'hCAFE_F00D, 32'h0000_0000, 1'b0};
        tbl[8]  = '{0, 1'b0, 32'h0000_03FF, 32'h0000_0000, 32'hCAFE_F00D, 1'b0};
        tbl[9]  = '{0, 1'b0, 32'h0000_07FF, 32'h0000_0000, 32'h0000_0000, 1'b1};
        tbl[10] = '{0, 1'b1, 32'h0000_0007, 32'h0000_0001, 32'h0000_0000, 1'b0};
        tbl[11] = '{0, 1'b0, 32'h0000_0007, 32'h0000_0000, 32'h0000_0001, 1'b0};
        tbl[12] = '{1, 1'b1, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 1'b0};
        tbl[13] = '{1, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h1234_5678, 1'b0};
        tbl[14] = '{1, 1'b0, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1};
        tbl[15] = '{1, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h1234_5678, 1'b0};

        rst_n      = 1'b1;
        req_valid  = '0;
        req_we     = '0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = '0;

        // Reset values, observed before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst%0d req_ready", d), {31'd0, req_ready[d]}, 32'd1);
            check($sformatf("rst%0d resp_valid", d), {31'd0, resp_valid[d]}, 32'd0);
            check($sformatf("rst%0d resp_rdata", d), resp_rdata[d], 32'd0);
            check($sformatf("rst%0d resp_err", d), {31'd0, resp_err[d]}, 32'd0);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) begin
            do_txn(tbl[i].d, tbl[i].we, tbl[i].addr, tbl[i].wdata,
                   tbl[i].exp_rdata, tbl[i].exp_err, $sformatf("v%0d", i));
        end

        // Zero-wait back-to-back: resp_ready held high ahead of resp_valid,
        // write accepted, handshake next edge, read accepted the edge after.
        resp_ready[1] = 1'b1;
        req_valid[1]  = 1'b1;
        req_we[1]     = 1'b1;
        req_addr[1]   = 32'h0000_0000;
        req_wdata[1]  = 32'hA5A5_0F0F;
        @(posedge clk); #1;
        check("b2b wr valid", {31'd0, resp_valid[1]}, 32'd1);
        check("b2b wr ready", {31'd0, req_ready[1]}, 32'd0);
        req_we[1]    = 1'b0;
        req_wdata[1] = 32'h0;
        @(posedge clk); #1;
        check("b2b hs valid", {31'd0, resp_valid[1]}, 32'd0);
        check("b2b hs ready", {31'd0, req_ready[1]}, 32'd1);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        check("b2b rd valid", {31'd0, resp_valid[1]}, 32'd1);
        check("b2b rd rdata", resp_rdata[1], 32'hA5A5_0F0F);
        @(posedge clk); #1;
        resp_ready[1] = 1'b0;
        check("b2b end valid", {31'd0, resp_valid[1]}, 32'd0);

        // Backpressure on the wait-state build: read address 5, hold the
        // response for 5 cycles, and pulse a write request that must be ignored.
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b0;
        req_addr[0]  = 32'h0000_0005;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        begin
            int n;
            n = 0;
            while (!resp_valid[0] && n < 40) begin
                @(posedge clk); #1;
                n++;
            end
            check("bp latency", n, 2);
        end
        for (int c = 0; c < 5; c++) begin
            check($sformatf("bp%0d valid", c), {31'd0, resp_valid[0]}, 32'd1);
            check($sformatf("bp%0d rdata", c), resp_rdata[0], 32'hDEAD_BEEF);
            check($sformatf("bp%0d ready", c), {31'd0, req_ready[0]}, 32'd0);
            req_valid[0] = (c == 2);
            req_we[0]    = 1'b1;
            req_wdata[0] = 32'h0;
            @(posedge clk); #1;
        end
        req_valid[0]  = 1'b0;
        resp_ready[0] = 1'b1;
        @(posedge clk); #1;
        resp_ready[0] = 1'b0;
        check("bp release ready", {31'd0, req_ready[0]}, 32'd1);
        check("bp release valid", {31'd0, resp_valid[0]}, 32'd0);
        do_txn(0, 1'b0, 32'h5, 32'h0, 32'hDEAD_BEEF, 1'b0, "bp reread");

        // Reset during WAIT: the pending write to address 7 must be dropped.
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b1;
        req_addr[0]  = 32'h0000_0007;
        req_wdata[0] = 32'hAAAA_5555;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        check("rstw in_wait ready", {31'd0, req_ready[0]}, 32'd0);
        #3 rst_n = 1'b0;
        #1;
        check("rstw async ready", {31'd0, req_ready[0]}, 32'd1);
        check("rstw async valid", {31'd0, resp_valid[0]}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        do_txn(0, 1'b0, 32'h7, 32'h0, 32'h0000_0001, 1'b0, "rstw reread");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
